// File: rtl/gpio_io_port.sv
// ============================================================================
// Module   : gpio_io_port
// Purpose  : Memory-side endpoint for the core's CSR-mapped I/O.
//            Write path: latches the HEX word on GPIO_we and scans it onto an
//            8-digit, time-multiplexed, active-low seven-segment display.
//            Read path: 2-FF synchronizes and debounces 18 board switches
//            into the 32-bit word returned to the core.
// Ports    : clk        core clock, rising edge
//            rst        asynchronous active-high reset
//            GPIO_we    HEX register write strobe
//            gpio_wdata HEX register write data
//            sw_in      raw asynchronous switch inputs
//            sw_rdata   debounced switch word {14'b0, sw[17:0]}
//            hex_reg    currently latched display value
//            seg_n      active-low segments {g,f,e,d,c,b,a}
//            dig_an_n   active-low digit enables, bit i = nibble i
// Options  : GPIO_LEAD_BLANK_EN - blank leading-zero digits (digit 0 never)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_io_port #(
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        GPIO_we,
    input  logic [31:0] gpio_wdata,
    input  logic [17:0] sw_in,
    output logic [31:0] sw_rdata,
    output logic [31:0] hex_reg,
    output logic [6:0]  seg_n,
    output logic [7:0]  dig_an_n
);

    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEB_CYCLES - 1);

    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [2:0]          r_idx;
    logic [17:0]         r_sync1;
    logic [17:0]         r_sync2;
    logic [17:0]         r_cand;
    logic [c_DEB_W-1:0]  r_deb_cnt;

    logic [3:0]          w_nibble;
    logic [6:0]          w_seg_on;
    logic                w_blank;
    logic [6:0]          w_seg_next;
    logic [7:0]          w_dig_next;

    // ------------------------------------------------------------------
    // HEX register: every strobed cycle is taken, last write wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_reg <= 32'd0;
        end else if (GPIO_we) begin
            hex_reg <= gpio_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
        end else if (r_scan_cnt == c_SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode for the digit currently selected.
    // ------------------------------------------------------------------
`ifdef GPIO_LEAD_BLANK_EN
    logic [31:0] w_upper;
`endif

    always_comb begin
        w_nibble = hex_reg[{r_idx, 2'b00} +: 4];
        case (w_nibble)
            4'h0:    w_seg_on = 7'h3F;
            4'h1:    w_seg_on = 7'h06;
            4'h2:    w_seg_on = 7'h5B;
            4'h3:    w_seg_on = 7'h4F;
            4'h4:    w_seg_on = 7'h66;
            4'h5:    w_seg_on = 7'h6D;
            4'h6:    w_seg_on = 7'h7D;
            4'h7:    w_seg_on = 7'h07;
            4'h8:    w_seg_on = 7'h7F;
            4'h9:    w_seg_on = 7'h6F;
            4'hA:    w_seg_on = 7'h77;
            4'hB:    w_seg_on = 7'h7C;
            4'hC:    w_seg_on = 7'h39;
            4'hD:    w_seg_on = 7'h5E;
            4'hE:    w_seg_on = 7'h79;
            default: w_seg_on = 7'h71;
        endcase
`ifdef GPIO_LEAD_BLANK_EN
        // Shifting the selected nibble down to bit 0 leaves only it and the
        // higher nibbles; all zero means this digit is a leading zero.
        w_upper = hex_reg >> {r_idx, 2'b00};
        w_blank = (r_idx != 3'd0) && (w_upper == 32'd0);
`else
        w_blank = 1'b0;
`endif
        w_seg_next = w_blank ? 7'h7F : ~w_seg_on;
        w_dig_next = ~(8'd1 << r_idx);
    end

    // Registered display outputs: dark during reset, first enabled digit
    // appears on the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n    <= 7'h7F;
            dig_an_n <= 8'hFF;
        end else begin
            seg_n    <= w_seg_next;
            dig_an_n <= w_dig_next;
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizer and debouncer. Any difference between the
    // synchronized vector and the candidate restarts the stability count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 18'd0;
            r_sync2   <= 18'd0;
            r_cand    <= 18'd0;
            r_deb_cnt <= '0;
            sw_rdata  <= 32'd0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand    <= r_sync2;
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_MAX) begin
                sw_rdata <= {14'd0, r_cand};
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
